// File: rtl/core_clock_ctrl.sv
// Tick generator for the CPU core. It produces a one-cycle clock enable at a fixed rate while running.
// It supports halt and single-step from two debounced buttons, plus a level halt request from the core.
module core_clock_ctrl #(
    parameter int INPUT_CLOCK  = 16_000_000,
    parameter int OUTPUT_CLOCK = 1,
    parameter int DEBOUNCE_MS  = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_run,
    input  logic       i_btn_step,
    input  logic       i_halt_req,
    output logic       o_tick,
    output logic [1:0] o_state,
    output logic       o_led_run
);

    localparam int PERIOD     = INPUT_CLOCK / OUTPUT_CLOCK;
    localparam int DEB_CYCLES = INPUT_CLOCK / 1000 * DEBOUNCE_MS;
    localparam int RC_W       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DC_W       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(PERIOD - 1);
    localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    // Bit 0 carries the run button and bit 1 carries the step button.
    logic [1:0]      w_btn;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_press;
    logic [DC_W-1:0] r_dc [2];

    state_t          r_state;
    logic [RC_W-1:0] r_rc;
    logic            r_tick;
    logic            r_led;

    assign w_btn = {i_btn_step, i_btn_run};

    // Synchronise, debounce and edge-detect both buttons; a press is the registered db rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_db    <= 2'b00;
            r_db_d  <= 2'b00;
            r_press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_dc[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dc[i] <= '0;
                end else if (r_dc[i] == DC_MAX) begin
                    r_db[i] <= r_sync2[i];
                    r_dc[i] <= '0;
                end else begin
                    r_dc[i] <= r_dc[i] + DC_W'(1);
                end
            end
        end
    end

    // Run/halt/step state machine with the rate counter; tick and LED are registered alongside state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_HALT;
            r_rc    <= '0;
            r_tick  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_led  <= 1'b0;
            case (r_state)
                ST_HALT: begin
                    r_rc <= '0;
                    if (r_press[0]) begin
                        r_state <= ST_RUN;
                        r_led   <= 1'b1;
                    end else if (r_press[1]) begin
                        r_state <= ST_STEP;
                        r_tick  <= 1'b1;
                    end else begin
                        r_state <= ST_HALT;
                    end
                end
                ST_RUN: begin
                    // A halt decided this cycle suppresses the tick even at the wrap point.
                    if (r_press[0] || i_halt_req) begin
                        r_state <= ST_HALT;
                        r_rc    <= '0;
                    end else begin
                        r_state <= ST_RUN;
                        r_led   <= 1'b1;
                        if (r_rc == RC_MAX) begin
                            r_rc   <= '0;
                            r_tick <= 1'b1;
                        end else begin
                            r_rc <= r_rc + RC_W'(1);
                        end
                    end
                end
                ST_STEP: begin
                    r_state <= ST_HALT;
                    r_rc    <= '0;
                end
                default: begin
                    r_state <= ST_HALT;
                    r_rc    <= '0;
                end
            endcase
        end
    end

    assign o_tick    = r_tick;
    assign o_state   = r_state;
    assign o_led_run = r_led;

endmodule

// File: tb/tb_core_clock_ctrl.sv
// Randomised bench for core_clock_ctrl. A behavioural model counts RUN cycles and debounce runs.
module tb_core_clock_ctrl;

    localparam int IN_CLK = 1000;
    localparam int OUT_CLK = 100;
    localparam int DEB_MS = 4;
    localparam int PERIOD = IN_CLK / OUT_CLK;
    localparam int DEB = IN_CLK / 1000 * DEB_MS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_run;
    logic       btn_step;
    logic       halt_req;
    logic       tick;
    logic [1:0] state;
    logic       led;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [1:0] m_state;
    logic       m_tick;
    int         m_run_cycles;
    logic [1:0] m_d1, m_d2, m_db, m_dbp, m_press;
    int         m_diff [2];
    logic [3:0] m_exp;

    core_clock_ctrl #(
        .INPUT_CLOCK (IN_CLK),
        .OUTPUT_CLOCK(OUT_CLK),
        .DEBOUNCE_MS (DEB_MS)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn_run (btn_run),
        .i_btn_step(btn_step),
        .i_halt_req(halt_req),
        .o_tick    (tick),
        .o_state   (state),
        .o_led_run (led)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 2'b00; m_tick = 1'b0; m_run_cycles = 0;
        m_d1 = 2'b00; m_d2 = 2'b00; m_db = 2'b00; m_dbp = 2'b00; m_press = 2'b00;
        m_diff[0] = 0; m_diff[1] = 0;
        m_exp = 4'b0000;
    endtask

    task automatic model_update();
        logic [1:0] s;
        logic [1:0] nstate;
        logic       nt;
        nstate = m_state;
        nt = 1'b0;
        case (m_state)
            2'b00: begin
                if (m_press[0]) begin nstate = 2'b01; m_run_cycles = 0; end
                else if (m_press[1]) begin nstate = 2'b10; nt = 1'b1; end
            end
            2'b01: begin
                if (m_press[0] || halt_req) nstate = 2'b00;
                else begin
                    if (m_run_cycles % PERIOD == PERIOD - 1) nt = 1'b1;
                    m_run_cycles++;
                end
            end
            default: nstate = 2'b00;
        endcase
        s = m_d2;
        m_press = m_db & ~m_dbp;
        m_dbp = m_db;
        for (int b = 0; b < 2; b++) begin
            if (s[b] != m_db[b]) begin
                m_diff[b]++;
                if (m_diff[b] == DEB) begin m_db[b] = s[b]; m_diff[b] = 0; end
            end else m_diff[b] = 0;
        end
        m_d2 = m_d1;
        m_d1 = {btn_step, btn_run};
        m_state = nstate;
        m_tick = nt;
        m_exp = {nt, nstate, nstate == 2'b01};
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic test_reset();
        btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0; rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({tick, state, led} !== 4'b0000) begin
            failures++; $display("FAIL reset_value got=%b expected=0000", {tick, state, led});
        end
        repeat (3) cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            cyc();
            checks++;
            if ({tick, state, led} !== 4'b0000) begin
                failures++; $display("FAIL idle_after_reset cycle=%0d got=%b expected=0000", c, {tick, state, led});
            end
        end
    endtask

    task automatic test_run_press();
        int entry = -1;
        int nticks = 0;
        int first = -1;
        logic prev = 1'b0;
        btn_run = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            if (c == 21) btn_run = 1'b0;
            cyc();
            checks++;
            if ({tick, state, led} !== m_exp) begin
                failures++; $display("FAIL lockstep_run t=%0t got=%b expected=%b", $time, {tick, state, led}, m_exp);
            end
            checks++;
            if (tick && prev) begin
                failures++; $display("FAIL tick_back_to_back_run t=%0t got=11 expected=not both 1", $time);
            end
            prev = tick;
            if (entry < 0 && state == 2'b01) entry = c;
            else if (entry >= 0 && c - entry <= 50 && tick) begin
                nticks++;
                if (first < 0) first = c - entry;
            end
        end
        checks++;
        if (entry < 0 || entry > DEB + 4) begin
            failures++; $display("FAIL run_entry_latency got=%0d expected=1..%0d", entry, DEB + 4);
        end
        checks++;
        if (first != PERIOD) begin
            failures++; $display("FAIL first_tick_offset got=%0d expected=%0d", first, PERIOD);
        end
        checks++;
        if (nticks != 5) begin
            failures++; $display("FAIL tick_count_50 got=%0d expected=5", nticks);
        end
        checks++;
        if (state !== 2'b01 || led !== 1'b1) begin
            failures++; $display("FAIL held_button_single_press got=%b/%b expected=01/1", state, led);
        end
    endtask

    task automatic test_glitch_halt();
        int len;
        int nt = 0;
        int guard = 0;
        len = $urandom_range(1, DEB - 1);
        btn_run = 1'b1;
        for (int c = 0; c < len; c++) begin
            cyc();
            checks++;
            if ({tick, state, led} !== m_exp) begin
                failures++; $display("FAIL lockstep_glitch t=%0t got=%b expected=%b", $time, {tick, state, led}, m_exp);
            end
        end
        btn_run = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            checks++;
            if (state !== 2'b01 || {tick, state, led} !== m_exp) begin
                failures++; $display("FAIL glitch_no_change t=%0t got=%b expected=%b", $time, {tick, state, led}, m_exp);
            end
            if (tick) nt++;
        end
        checks++;
        if (nt != 2) begin
            failures++; $display("FAIL ticks_after_glitch got=%0d expected=2", nt);
        end
        while (m_run_cycles % PERIOD != PERIOD - 1 && guard < 2 * PERIOD) begin
            cyc();
            guard++;
        end
        checks++;
        if (guard >= 2 * PERIOD) begin
            failures++; $display("FAIL halt_align_timeout got=%0d expected<%0d", guard, 2 * PERIOD);
        end
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        checks++;
        if ({tick, state, led} !== 4'b0000) begin
            failures++; $display("FAIL halt_at_wrap got=%b expected=0000", {tick, state, led});
        end
        for (int c = 0; c < 30; c++) begin
            cyc();
            checks++;
            if ({tick, state, led} !== 4'b0000) begin
                failures++; $display("FAIL halted_quiet cycle=%0d got=%b expected=0000", c, {tick, state, led});
            end
        end
    endtask

    task automatic test_step();
        int nsteps = 0;
        int hi;
        int lo;
        logic prev = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hi = $urandom_range(DEB, DEB + 6);
            lo = $urandom_range(DEB + 8, DEB + 14);
            btn_step = 1'b1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) btn_step = 1'b0;
                cyc();
                checks++;
                if ({tick, state, led} !== m_exp) begin
                    failures++; $display("FAIL lockstep_step t=%0t got=%b expected=%b", $time, {tick, state, led}, m_exp);
                end
                checks++;
                if (tick !== (state == 2'b10) || (tick && prev)) begin
                    failures++; $display("FAIL step_tick_shape t=%0t got=%b/%b expected=tick iff state 10", $time, tick, state);
                end
                if (tick) nsteps++;
                prev = tick;
            end
        end
        checks++;
        if (nsteps != 3 || state !== 2'b00) begin
            failures++; $display("FAIL step_count got=%0d/%b expected=3/00", nsteps, state);
        end
    endtask

    task automatic test_random();
        int seg = 0;
        logic prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 14);
                btn_run = ($urandom_range(0, 3) == 0);
                btn_step = ($urandom_range(0, 2) == 0);
            end
            seg--;
            halt_req = ($urandom_range(0, 15) == 0);
            cyc();
            checks++;
            if ({tick, state, led} !== m_exp || (tick && prev)) begin
                failures++; $display("FAIL lockstep_random t=%0t got=%b expected=%b", $time, {tick, state, led}, m_exp);
            end
            prev = tick;
        end
        btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0;
        repeat (20) cyc();
        if (state == 2'b01) begin
            halt_req = 1'b1;
            cyc();
            halt_req = 1'b0;
        end
        repeat (5) cyc();
        checks++;
        if ({tick, state, led} !== m_exp || state !== 2'b00) begin
            failures++; $display("FAIL random_settle got=%b expected=%b", {tick, state, led}, m_exp);
        end
    endtask

    task automatic test_simultaneous();
        int entry = -1;
        int first = -1;
        logic saw_step = 1'b0;
        btn_run = 1'b1;
        btn_step = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 13) begin btn_run = 1'b0; btn_step = 1'b0; end
            cyc();
            checks++;
            if ({tick, state, led} !== m_exp) begin
                failures++; $display("FAIL lockstep_simul t=%0t got=%b expected=%b", $time, {tick, state, led}, m_exp);
            end
            if (state == 2'b10) saw_step = 1'b1;
            if (entry < 0 && state == 2'b01) entry = c;
            else if (entry >= 0 && tick && first < 0) first = c - entry;
        end
        checks++;
        if (saw_step || entry < 0) begin
            failures++; $display("FAIL simul_run_wins got=step%0d/entry%0d expected=step0/entry>=0", saw_step, entry);
        end
        checks++;
        if (first != PERIOD) begin
            failures++; $display("FAIL simul_first_tick got=%0d expected=%0d", first, PERIOD);
        end
    endtask

    task automatic test_reset_midrun();
        int guard = 0;
        while (!(m_state == 2'b01 && m_run_cycles % PERIOD == 7) && guard < 3 * PERIOD) begin
            cyc();
            guard++;
        end
        checks++;
        if (guard >= 3 * PERIOD || state !== 2'b01) begin
            failures++; $display("FAIL midrun_align got=%0d/%b expected=<%0d/01", guard, state, 3 * PERIOD);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tick, state, led} !== 4'b0000) begin
            failures++; $display("FAIL async_reset_midrun got=%b expected=0000", {tick, state, led});
        end
        model_reset();
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc();
            checks++;
            if ({tick, state, led} !== 4'b0000) begin
                failures++; $display("FAIL post_reset_halt cycle=%0d got=%b expected=0000", c, {tick, state, led});
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_press();
        test_glitch_halt();
        test_step();
        test_random();
        test_simultaneous();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
